vedic_mul_seq: RTL and testbench

//  Multi-cycle WIDTHxWIDTH unsigned multiplier built from a single 4x4 Vedic core.

---
 rtl/vedic_pkg.sv | 17 +
 rtl/vedic_mul4.sv | 24 ++
 rtl/vedic_mul_seq.sv | 116 +++++++++++
 tb/tb_vedic_mul_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vedic_pkg.sv
// Shared constants, state encoding and step-count helper for the sequential Vedic multiplier.
package vedic_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  // One nibble product per step: (WIDTH/4)^2 steps cover every nibble pair.
  function automatic int step_count(input int width);
    return (width / NIB_W) * (width / NIB_W);
  endfunction

endpackage

// File: rtl/vedic_mul4.sv
// Combinational 4x4 -> 8-bit Urdhva-Tiryagbhyam (vertical and crosswise) multiplier core.
module vedic_mul4
  import vedic_pkg::*;
(
  input  logic [NIB_W-1:0]   a,
  input  logic [NIB_W-1:0]   b,
  output logic [2*NIB_W-1:0] p
);

  logic [7:0] col0, col1, col2, col3, col4, col5, col6;

  // Each column gathers the crosswise partial products of equal weight.
  assign col0 = 8'(a[0] & b[0]);
  assign col1 = 8'(a[1] & b[0]) + 8'(a[0] & b[1]);
  assign col2 = 8'(a[2] & b[0]) + 8'(a[1] & b[1]) + 8'(a[0] & b[2]);
  assign col3 = 8'(a[3] & b[0]) + 8'(a[2] & b[1]) + 8'(a[1] & b[2]) + 8'(a[0] & b[3]);
  assign col4 = 8'(a[3] & b[1]) + 8'(a[2] & b[2]) + 8'(a[1] & b[3]);
  assign col5 = 8'(a[3] & b[2]) + 8'(a[2] & b[3]);
  assign col6 = 8'(a[3] & b[3]);

  assign p = col0 + (col1 << 1) + (col2 << 2) + (col3 << 3)
           + (col4 << 4) + (col5 << 5) + (col6 << 6);

endmodule

// File: rtl/vedic_mul_seq.sv
// Multi-cycle WIDTHxWIDTH unsigned multiplier reusing one 4x4 Vedic core, one nibble pair per cycle.
// Optional VEDIC_SEQ_ZERO_SKIP_EN: a zero operand bypasses CALC and returns 0 one edge after accept.
module vedic_mul_seq
  import vedic_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p,
  output logic               busy
);

  localparam int N     = WIDTH / NIB_W;
  localparam int STEPS = step_count(WIDTH);
  localparam int IW    = (N > 1) ? $clog2(N) : 1;
  localparam int P_W   = 2 * WIDTH;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  state_e               state;
  logic [WIDTH-1:0]     a_q, b_q;
  logic [P_W-1:0]       acc;
  logic [IW-1:0]        i_q, j_q;
  logic [NIB_W-1:0]     nib_a, nib_b;
  logic [2*NIB_W-1:0]   nib_p;
  logic [P_W-1:0]       term;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  assign nib_a = a_q[NIB_W*i_q +: NIB_W];
  assign nib_b = b_q[NIB_W*j_q +: NIB_W];
  assign term  = P_W'(nib_p) << (NIB_W * (int'(i_q) + int'(j_q)));

  vedic_mul4 u_core (
    .a (nib_a),
    .b (nib_b),
    .p (nib_p)
  );

  // j walks the multiplier nibbles fastest; the last (i,j) pair folds straight into out_p.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_p     <= '0;
      acc       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
            acc <= '0;
            i_q <= '0;
            j_q <= '0;
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
            if (in_a == '0 || in_b == '0) state <= DONE;
            else                          state <= CALC;
`else
            state <= CALC;
`endif
          end
        end
        CALC: begin
          acc <= acc + term;
          if (j_q == LAST) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
          if (i_q == LAST && j_q == LAST) begin
            state     <= DONE;
            out_p     <= acc + term;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
`ifdef VEDIC_SEQ_ZERO_SKIP_EN
          // Arriving here without a valid result means the zero shortcut was taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_p     <= '0;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
`else
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

  // STEPS documents the schedule length; it must match the nibble walk above.
  if (STEPS != N * N) begin : g_bad_steps
    $error("vedic_mul_seq: step count mismatch");
  end

endmodule

// File: tb/tb_vedic_mul_seq.sv
// Directed and randomised self-checking bench for vedic_mul_seq (WIDTH=16, 16-step latency).
module tb_vedic_mul_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_a, in_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_p;
  logic        busy;

  int errors = 0;
  int checks = 0;

`ifdef VEDIC_SEQ_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  vedic_mul_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int expLat(input logic [15:0] a, input logic [15:0] b);
    return (SKIP && (a == 16'h0 || b == 16'h0)) ? 1 : 16;
  endfunction

  // Present one operand pair, get it accepted, then count edges until out_valid.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input bit noise,
                               output int lat, output int busy_accepts);
    int n;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    tick;
    in_valid     = 1'b0;
    lat          = 0;
    busy_accepts = 0;
    while (!out_valid && lat < 40) begin
      if (in_ready) busy_accepts++;
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        in_a     = 16'($urandom);
        in_b     = 16'($urandom);
      end
      tick;
      lat++;
    end
    in_valid = 1'b0;
  endtask

  task automatic drainOutput(input string tag, input int hold, input logic [31:0] exp);
    out_ready = 1'b0;
    for (int k = 0; k < hold; k++) begin
      tick;
      if (out_valid !== 1'b1 || out_p !== exp) checkOutput({tag, "_hold"}, {out_valid, out_p}, {1'b1, exp});
    end
    out_ready = 1'b1;
    tick;
    checkOutput({tag, "_drop"}, out_valid, 1'b0);
    out_ready = 1'b0;
  endtask

  initial begin
    int lat, bad, seen;
    logic [15:0] ra, rb;
    logic [31:0] exp;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;

    // T1: reset state
    tick; tick;
    rst = 1'b0;
    tick;
    checkOutput("rst_out_valid", out_valid, 1'b0);
    checkOutput("rst_out_p", out_p, 32'h0);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_in_ready", in_ready, 1'b1);

    // T2: small product, full latency
    applyStimulus(16'h0003, 16'h0005, 1'b0, lat, bad);
    checkOutput("t2_latency", lat, 16);
    checkOutput("t2_product", out_p, 32'h0000_000F);
    checkOutput("t2_busy", busy, 1'b1);
    drainOutput("t2", 0, 32'h0000_000F);

    // T3: maximum operands, sink stalls for 5 cycles
    applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, lat, bad);
    checkOutput("t3_latency", lat, 16);
    checkOutput("t3_product", out_p, 32'hFFFE_0001);
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      checkOutput("t3_hold_valid", out_valid, 1'b1);
      checkOutput("t3_hold_p", out_p, 32'hFFFE_0001);
    end
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    checkOutput("t3_drop_valid", out_valid, 1'b0);
    checkOutput("t3_idle_busy", busy, 1'b0);
    checkOutput("t3_p_held", out_p, 32'hFFFE_0001);

    // T4: reset mid-calculation discards the product
    in_a = 16'h1234; in_b = 16'h0ABC; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    repeat (6) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checkOutput("t4_rst_busy", busy, 1'b0);
    checkOutput("t4_rst_in_ready", in_ready, 1'b1);
    checkOutput("t4_rst_out_p", out_p, 32'h0);
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick;
      if (out_valid) seen++;
    end
    checkOutput("t4_no_valid", seen, 0);
    applyStimulus(16'h00FF, 16'h0101, 1'b0, lat, bad);
    checkOutput("t4_latency", lat, 16);
    checkOutput("t4_product", out_p, 32'h0000_FFFF);
    drainOutput("t4", 2, 32'h0000_FFFF);

    // T5: zero operand
    applyStimulus(16'h0000, 16'hBEEF, 1'b0, lat, bad);
    checkOutput("t5_latency", lat, SKIP ? 1 : 16);
    checkOutput("t5_product", out_p, 32'h0);
    drainOutput("t5", 1, 32'h0);

    // T6: random pairs with gaps, input noise while busy, out_ready tied high in the second half
    for (int t = 0; t < 1000; t++) begin
      ra  = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom);
      rb  = ($urandom_range(0, 15) == 0) ? 16'h0 : 16'($urandom);
      exp = 32'(ra) * 32'(rb);
      if (t >= 500) out_ready = 1'b1;
      repeat ($urandom_range(0, 2)) tick;
      applyStimulus(ra, rb, 1'b1, lat, bad);
      checkOutput("t6_latency", lat, expLat(ra, rb));
      checkOutput("t6_product", out_p, exp);
      checkOutput("t6_busy_accept", bad, 0);
      if (t < 500) drainOutput("t6", $urandom_range(0, 3), exp);
      else begin
        tick;
        checkOutput("t6_tied_drop", out_valid, 1'b0);
      end
    end
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
